// File: rtl/tft_host_pkg.sv
// tft_host_pkg: shared definitions for the TFT host interface.
//   cmd_e   - command codes written over the 8080 bus (low nibble of DATA in a
//             command cycle) selecting which register a following data write hits.
//   state_e - host bus FSM states.
package tft_host_pkg;

   typedef enum logic [3:0] {
      CMD_NOP       = 4'h0,
      CMD_BACKLIGHT = 4'h1,
      CMD_ROW_S     = 4'h2,
      CMD_COL_S     = 4'h3,
      CMD_PAGE_SHOW = 4'h4,
      CMD_PAGE_SET  = 4'h5,
      CMD_ROW_E     = 4'h6,
      CMD_COL_E     = 4'h7,
      CMD_SLEEP     = 4'hB,
      CMD_DISP_MODE = 4'hC,
      CMD_INC_MODE  = 4'hD,
      CMD_DATA      = 4'hF
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      WR_CMD,
      WR_DATA,
      RD_DATA,
      END
   } state_e;

endpackage

// File: rtl/tft_addr_cnt.sv
// tft_addr_cnt: window address counter.
//   osc_clk, RST - clock, async active-low clear
//   ld, ld_val   - synchronous load (wins over en)
//   en           - count enable, wraps mod 2^WIDTH
//   cnt          - current address
module tft_addr_cnt #(
   parameter int WIDTH = 10
) (
   input  logic             osc_clk,
   input  logic             RST,
   input  logic             ld,
   input  logic             en,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge osc_clk or negedge RST) begin
      if (!RST)    cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (en) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tft_host_if.sv
// tft_host_if: 8080-style host register/pixel interface of the TFT controller.
//   osc_clk, RST         - clock, async active-low reset
//   DATA, CS, RS, WR, RD - host bus (DATA is read back as 0x0000 for one cycle)
//   LR, UD, pwm_backlight, page_show, page_set - display control registers
//   row_add, col_add     - write-window address, advanced by startup_inc
//   FIFO_RD_req, FIFO_full, FIFO_data - one-entry pixel hand-off to the writer
//   startup              - sticky, set once the first full window completes
module tft_host_if
   import tft_host_pkg::*;
#(
   parameter int ROWS = 480,
   parameter int COLS = 800
) (
   input  logic        osc_clk,
   input  logic        RST,
   inout  wire  [15:0] DATA,
   input  logic        CS,
   input  logic        RS,
   input  logic        WR,
   input  logic        RD,
   output logic        LR,
   output logic        UD,
   output logic [3:0]  pwm_backlight,
   output logic [2:0]  page_show,
   output logic [2:0]  page_set,
   output logic [8:0]  row_add,
   output logic [9:0]  col_add,
   input  logic        startup_inc,
   input  logic        FIFO_RD_req,
   output logic        FIFO_full,
   output logic [15:0] FIFO_data,
   output logic        startup
);

   localparam logic [8:0] ROW_MAX = 9'(ROWS - 1);
   localparam logic [9:0] COL_MAX = 10'(COLS - 1);

   state_e      state, state_nx;
   logic        do_cmd, do_data, do_rd;
   logic [3:0]  cmd;
   logic        row_first, reload, rd_oe;
   logic [8:0]  row_start, row_end;
   logic [9:0]  col_start, col_end;
   logic        col_done, row_done, col_en, row_en, col_ld, row_ld;
   // Power-up value only: startup survives RST by design.
   logic        startup_r = 1'b0;

   // ---- bus FSM ----
   always_ff @(posedge osc_clk or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            case ({CS, RS, WR, RD})
               4'b0001: state_nx = WR_CMD;
               4'b0101: state_nx = WR_DATA;
               4'b0110: state_nx = RD_DATA;
               default: state_nx = IDLE;
            endcase
         end
         WR_CMD, WR_DATA, RD_DATA: state_nx = END;
         // Hold until the strobe is released so a long strobe acts once.
         END:     if (CS || (WR && RD)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      do_cmd  = (state == WR_CMD);
      do_data = (state == WR_DATA);
      do_rd   = (state == RD_DATA);
   end

   // ---- register file ----
   always_ff @(posedge osc_clk or negedge RST) begin
      if (!RST) begin
         cmd           <= '0;
         pwm_backlight <= '0;
         page_show     <= '0;
         page_set      <= '0;
         LR            <= 1'b0;
         UD            <= 1'b0;
         row_first     <= 1'b0;
         row_start     <= '0;
         col_start     <= '0;
         row_end       <= ROW_MAX;
         col_end       <= COL_MAX;
         FIFO_full     <= 1'b0;
         FIFO_data     <= '0;
         reload        <= 1'b0;
         rd_oe         <= 1'b0;
      end else begin
         reload <= 1'b0;
         rd_oe  <= do_rd;
         if (do_cmd) cmd <= DATA[3:0];
         if (do_data) begin
            case (cmd)
               CMD_BACKLIGHT: pwm_backlight <= DATA[3:0];
               CMD_ROW_S: if (DATA[8:0] <= row_end) begin
                  row_start <= DATA[8:0];
                  reload    <= 1'b1;
               end
               CMD_COL_S: if (DATA[9:0] <= col_end) begin
                  col_start <= DATA[9:0];
                  reload    <= 1'b1;
               end
               CMD_ROW_E:     if (DATA[8:0] <= ROW_MAX) row_end <= DATA[8:0];
               CMD_COL_E:     if (DATA[9:0] <= COL_MAX) col_end <= DATA[9:0];
               CMD_PAGE_SHOW: page_show <= DATA[2:0];
               CMD_PAGE_SET:  page_set  <= DATA[2:0];
               CMD_DISP_MODE: {UD, LR}  <= DATA[1:0];
               CMD_INC_MODE:  row_first <= DATA[0];
               CMD_DATA: if (!FIFO_full) begin
                  FIFO_data <= DATA;
                  FIFO_full <= 1'b1;
               end
               default: ;
            endcase
         end else if (FIFO_RD_req) begin
            // Writer's consume is only honoured outside data-write cycles.
            FIFO_full <= 1'b0;
         end
      end
   end

   assign DATA = rd_oe ? 16'h0000 : 16'hzzzz;

   // ---- window address generation ----
   assign col_done = (col_add == col_end);
   assign row_done = (row_add == row_end);
   assign col_en   = (~row_first | row_done) & startup_inc;
   assign row_en   = (row_first | col_done) & startup_inc;
   assign col_ld   = reload | (col_done & col_en);
   assign row_ld   = reload | (row_done & row_en);

   tft_addr_cnt #(.WIDTH(10)) u_col_cnt (
      .osc_clk (osc_clk),
      .RST     (RST),
      .ld      (col_ld),
      .en      (col_en),
      .ld_val  (col_start),
      .cnt     (col_add)
   );

   tft_addr_cnt #(.WIDTH(9)) u_row_cnt (
      .osc_clk (osc_clk),
      .RST     (RST),
      .ld      (row_ld),
      .en      (row_en),
      .ld_val  (row_start),
      .cnt     (row_add)
   );

   always_ff @(posedge osc_clk) begin
      if (col_en & col_done & row_done) startup_r <= 1'b1;
   end
   assign startup = startup_r;

endmodule

// File: tb/tb_tft_host_if.sv
module tb_tft_host_if;

   logic        osc_clk = 1'b0;
   logic        RST = 1'b0;
   logic        CS = 1'b1, RS = 1'b1, WR = 1'b1, RD = 1'b1;
   logic        startup_inc = 1'b0, FIFO_RD_req = 1'b0;
   logic        host_oe = 1'b0;
   logic [15:0] host_d = '0;
   wire  [15:0] DATA;
   logic        LR, UD, FIFO_full, startup;
   logic [3:0]  pwm_backlight;
   logic [2:0]  page_show, page_set;
   logic [8:0]  row_add;
   logic [9:0]  col_add;
   logic [15:0] FIFO_data;
   int          n_pass = 0, n_total = 0;

   // Released bus reads as 0xFFFF so high-Z is distinguishable from a driven 0.
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (DATA[i]);
   end
   assign DATA = host_oe ? host_d : 16'hzzzz;

   always #5 osc_clk = ~osc_clk;

   tft_host_if #(.ROWS(480), .COLS(800)) dut (
      .osc_clk(osc_clk), .RST(RST), .DATA(DATA), .CS(CS), .RS(RS), .WR(WR), .RD(RD),
      .LR(LR), .UD(UD), .pwm_backlight(pwm_backlight), .page_show(page_show),
      .page_set(page_set), .row_add(row_add), .col_add(col_add),
      .startup_inc(startup_inc), .FIFO_RD_req(FIFO_RD_req), .FIFO_full(FIFO_full),
      .FIFO_data(FIFO_data), .startup(startup)
   );

   // One complete host write; rs=0 command, rs=1 data; WR held low for hold cycles.
   task automatic bus_write(input logic rs, input logic [15:0] d, input int hold);
      @(negedge osc_clk);
      CS = 1'b0; RS = rs; WR = 1'b0; RD = 1'b1; host_d = d; host_oe = 1'b1;
      repeat (hold) @(negedge osc_clk);
      CS = 1'b1; WR = 1'b1; host_oe = 1'b0;
      repeat (2) @(negedge osc_clk);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) @(negedge osc_clk);
      n_total++;
      if ({LR, UD, pwm_backlight, page_show, page_set, row_add, col_add, FIFO_full, FIFO_data} !== 48'h0)
         $display("FAIL reset_outputs: got %h want 0",
                  {LR, UD, pwm_backlight, page_show, page_set, row_add, col_add, FIFO_full, FIFO_data});
      else n_pass++;
      n_total++;
      if (DATA !== 16'hFFFF) $display("FAIL reset_bus_hiz: got %h want ffff", DATA); else n_pass++;
      n_total++;
      if (startup !== 1'b0) $display("FAIL reset_startup: got %b want 0", startup); else n_pass++;
      RST = 1'b1;
      repeat (2) @(negedge osc_clk);
   endtask

   task automatic test_regs();
      bus_write(1'b0, 16'h0006, 3); bus_write(1'b1, 16'd480, 3);  // row_end 480 rejected
      bus_write(1'b0, 16'h0002, 3); bus_write(1'b1, 16'd480, 3);  // so row_start 480 rejected
      n_total++;
      if (row_add !== 9'd0) $display("FAIL row_end_range: got %0d want 0", row_add); else n_pass++;
      bus_write(1'b1, 16'd479, 3);
      n_total++;
      if (row_add !== 9'd479) $display("FAIL row_start_max: got %0d want 479", row_add); else n_pass++;
      bus_write(1'b0, 16'h0007, 3); bus_write(1'b1, 16'd799, 3);
      bus_write(1'b0, 16'h0003, 3); bus_write(1'b1, 16'd799, 3);
      n_total++;
      if (col_add !== 10'd799) $display("FAIL col_start_max: got %0d want 799", col_add); else n_pass++;
      bus_write(1'b1, 16'd800, 3);
      n_total++;
      if (col_add !== 10'd799) $display("FAIL col_start_range: got %0d want 799", col_add); else n_pass++;
      bus_write(1'b0, 16'h0001, 3); bus_write(1'b1, 16'h000A, 3);
      n_total++;
      if (pwm_backlight !== 4'hA) $display("FAIL backlight: got %h want a", pwm_backlight); else n_pass++;
      bus_write(1'b0, 16'h000C, 3); bus_write(1'b1, 16'h0002, 3);
      n_total++;
      if ({UD, LR} !== 2'b10) $display("FAIL disp_mode: got %b want 10", {UD, LR}); else n_pass++;
      bus_write(1'b0, 16'h0005, 3); bus_write(1'b1, 16'h0006, 3);
      bus_write(1'b0, 16'h0004, 3); bus_write(1'b1, 16'hFFF9, 3);
      n_total++;
      if ({page_set, page_show} !== 6'b110_001)
         $display("FAIL pages: got %b want 110001", {page_set, page_show});
      else n_pass++;
   endtask

   task automatic test_window(input logic rf);
      int r0[7] = '{1, 1, 1, 2, 2, 2, 1};
      int c0[7] = '{2, 3, 4, 2, 3, 4, 2};
      int r1[7] = '{1, 2, 1, 2, 1, 2, 1};
      int c1[7] = '{2, 2, 3, 3, 4, 4, 2};
      int er, ec;
      bus_write(1'b0, 16'h000D, 3); bus_write(1'b1, {15'd0, rf}, 3);
      bus_write(1'b0, 16'h0007, 3); bus_write(1'b1, 16'd4, 3);
      bus_write(1'b0, 16'h0006, 3); bus_write(1'b1, 16'd2, 3);
      bus_write(1'b0, 16'h0003, 3); bus_write(1'b1, 16'd2, 3);
      bus_write(1'b0, 16'h0002, 3); bus_write(1'b1, 16'd1, 3);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge osc_clk);
         er = rf ? r1[i] : r0[i];
         ec = rf ? c1[i] : c0[i];
         n_total++;
         if ({row_add, col_add} !== {9'(er), 10'(ec)})
            $display("FAIL window_rf%0d_step%0d: got (%0d,%0d) want (%0d,%0d)",
                     rf, i, row_add, col_add, er, ec);
         else n_pass++;
         if (i == 5 && !rf) begin
            n_total++;
            if (startup !== 1'b0) $display("FAIL startup_early: got %b want 0", startup); else n_pass++;
         end
         if (i == 0) startup_inc = 1'b1;
      end
      startup_inc = 1'b0;
      n_total++;
      if (startup !== 1'b1) $display("FAIL startup_set_rf%0d: got %b want 1", rf, startup); else n_pass++;
   endtask

   task automatic test_fifo();
      bus_write(1'b0, 16'h000F, 3);
      bus_write(1'b1, 16'h1234, 3);
      bus_write(1'b1, 16'h5678, 3);
      n_total++;
      if ({FIFO_full, FIFO_data} !== {1'b1, 16'h1234})
         $display("FAIL fifo_drop: got %b/%h want 1/1234", FIFO_full, FIFO_data);
      else n_pass++;
      @(negedge osc_clk); FIFO_RD_req = 1'b1;
      @(negedge osc_clk); FIFO_RD_req = 1'b0;
      n_total++;
      if (FIFO_full !== 1'b0) $display("FAIL fifo_consume: got %b want 0", FIFO_full); else n_pass++;
   endtask

   task automatic test_long_strobe();
      @(negedge osc_clk);
      CS = 1'b0; RS = 1'b1; WR = 1'b0; host_d = 16'hBEEF; host_oe = 1'b1;
      repeat (3) @(negedge osc_clk);
      n_total++;
      if ({FIFO_full, FIFO_data} !== {1'b1, 16'hBEEF})
         $display("FAIL hold_first: got %b/%h want 1/beef", FIFO_full, FIFO_data);
      else n_pass++;
      FIFO_RD_req = 1'b1;
      @(negedge osc_clk); FIFO_RD_req = 1'b0;
      n_total++;
      if (FIFO_full !== 1'b0) $display("FAIL hold_consume: got %b want 0", FIFO_full); else n_pass++;
      repeat (6) @(negedge osc_clk);
      n_total++;
      if (FIFO_full !== 1'b0) $display("FAIL hold_single_update: got %b want 0", FIFO_full); else n_pass++;
      CS = 1'b1; WR = 1'b1; host_oe = 1'b0;
      repeat (2) @(negedge osc_clk);
      n_total++;
      if (FIFO_full !== 1'b0) $display("FAIL hold_release: got %b want 0", FIFO_full); else n_pass++;
   endtask

   task automatic test_read();
      @(negedge osc_clk);
      CS = 1'b0; RS = 1'b1; WR = 1'b1; RD = 1'b0;
      @(negedge osc_clk);
      n_total++;
      if (DATA !== 16'hFFFF) $display("FAIL read_pre: got %h want ffff", DATA); else n_pass++;
      @(negedge osc_clk);
      n_total++;
      if (DATA !== 16'h0000) $display("FAIL read_drive: got %h want 0000", DATA); else n_pass++;
      @(negedge osc_clk);
      n_total++;
      if (DATA !== 16'hFFFF) $display("FAIL read_release: got %h want ffff", DATA); else n_pass++;
      CS = 1'b1; RD = 1'b1;
      repeat (2) @(negedge osc_clk);
   endtask

   task automatic test_reset_mid();
      bus_write(1'b0, 16'h0001, 3);
      @(negedge osc_clk);
      CS = 1'b0; RS = 1'b1; WR = 1'b0; host_d = 16'h0005; host_oe = 1'b1;
      repeat (3) @(negedge osc_clk);
      n_total++;
      if (pwm_backlight !== 4'h5) $display("FAIL mid_pre: got %h want 5", pwm_backlight); else n_pass++;
      #2 RST = 1'b0;
      #1;
      n_total++;
      if ({LR, UD, pwm_backlight, page_show, page_set, row_add, col_add, FIFO_full, FIFO_data} !== 48'h0)
         $display("FAIL mid_reset_regs: got %h want 0",
                  {LR, UD, pwm_backlight, page_show, page_set, row_add, col_add, FIFO_full, FIFO_data});
      else n_pass++;
      n_total++;
      if (startup !== 1'b1) $display("FAIL mid_reset_startup: got %b want 1", startup); else n_pass++;
      @(negedge osc_clk);
      CS = 1'b1; WR = 1'b1; host_oe = 1'b0;
      @(negedge osc_clk);
      RST = 1'b1;
      repeat (2) @(negedge osc_clk);
      bus_write(1'b0, 16'h0004, 3); bus_write(1'b1, 16'h0005, 3);
      n_total++;
      if ({page_show, pwm_backlight} !== {3'd5, 4'h0})
         $display("FAIL post_reset_write: got %h/%h want 5/0", page_show, pwm_backlight);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_regs();
      test_window(1'b0);
      test_window(1'b1);
      test_fifo();
      test_long_strobe();
      test_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
